// File: rtl/vp_cfg_pkg.sv
// ---------------------------------------------------------------------------
// vp_cfg_pkg
// Shared definitions for the video-pipeline configuration sequencer:
//   - sequencer state encoding
//   - CR field positions, START/END/SCALER X/Y field layout, THRESHOLD fields
//   - the bundled register-set type and small field/compare helpers
// ---------------------------------------------------------------------------
package vp_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_MUTE  = 2'd2
  } state_e;

  // CR fields: vp_mode at [2:1] up to fill_mode at [23:22]; bits [23:1]
  // together select the pipeline structure.
  localparam int CR_VP_MODE_LSB   = 1;
  localparam int CR_VP_MODE_W     = 2;
  localparam int CR_FILL_MODE_LSB = 22;
  localparam int CR_FILL_MODE_W   = 2;
  localparam int CR_STRUCT_LSB    = 1;
  localparam int CR_STRUCT_MSB    = 23;

  // START / END / SCALER words carry an 11-bit X at 0 and an 11-bit Y at 16.
  localparam int FLD_X_LSB = 0;
  localparam int FLD_Y_LSB = 16;
  localparam int FLD_W     = 11;

  // THRESHOLD word: edger level [7:0], binarizer level [15:8].
  localparam int THR_EDGER_LSB = 0;
  localparam int THR_BIN_LSB   = 8;
  localparam int THR_W         = 8;

  typedef struct packed {
    logic [31:0] cr;
    logic [31:0] start;
    logic [31:0] stop;
    logic [31:0] scaler;
    logic [31:0] threshold;
  } cfg_set_t;

  function automatic logic [FLD_W-1:0] fld_x(input logic [31:0] w);
    return w[FLD_X_LSB +: FLD_W];
  endfunction

  function automatic logic [FLD_W-1:0] fld_y(input logic [31:0] w);
    return w[FLD_Y_LSB +: FLD_W];
  endfunction

  // A change that forces line buffers / scaler to flush (threshold excluded).
  function automatic logic is_structural(input cfg_set_t a, input cfg_set_t b);
    return (a.cr[CR_STRUCT_MSB:CR_STRUCT_LSB] != b.cr[CR_STRUCT_MSB:CR_STRUCT_LSB]) ||
           (a.start != b.start) || (a.stop != b.stop) || (a.scaler != b.scaler);
  endfunction

endpackage

// File: rtl/vp_cfg_check.sv
// ---------------------------------------------------------------------------
// vp_cfg_check
// Combinational validator for a proposed register set.
// Ports:
//   cr_i, start_i, end_i, scaler_i, threshold_i : proposed 32-bit words
//   cfg_ok_o : 1 when the window is non-empty and the output resolution is
//              non-zero and within H_DISP x V_DISP
// ---------------------------------------------------------------------------
module vp_cfg_check
  import vp_cfg_pkg::*;
#(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720
) (
  input  logic [31:0] cr_i,
  input  logic [31:0] start_i,
  input  logic [31:0] end_i,
  input  logic [31:0] scaler_i,
  input  logic [31:0] threshold_i,
  output logic        cfg_ok_o
);

  logic win_ok_s;
  logic res_nz_s;
  logic res_fit_s;

  // CR and THRESHOLD impose no validity constraints today.
  logic unused_words_s;
  assign unused_words_s = ^{cr_i, threshold_i};

  assign win_ok_s  = (fld_x(end_i) > fld_x(start_i)) && (fld_y(end_i) > fld_y(start_i));
  assign res_nz_s  = (fld_x(scaler_i) != 11'd0) && (fld_y(scaler_i) != 11'd0);
  assign res_fit_s = (fld_x(scaler_i) <= 11'(H_DISP)) && (fld_y(scaler_i) <= 11'(V_DISP));
  assign cfg_ok_o  = win_ok_s & res_nz_s & res_fit_s;

endmodule

// File: rtl/vp_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// vp_cfg_sequencer
// Frame-synchronous configuration controller. Accepts a register set over a
// valid/ready handshake, validates it, and commits it atomically on the next
// vs rising edge. Structural changes mute the output for SETTLE_FRAMES frames.
// Optional build macro: VP_CFG_VS_TIMEOUT_EN adds a vs watchdog that
// force-commits after TIMEOUT_CYCLES and raises the sticky vs_lost flag.
// Ports:
//   clk, rst_n (synchronous, active-low), vs_in
//   cfg_valid/cfg_ready + cfg_cr/start/end/scaler/threshold : proposed set
//   act_cr/start/end/scaler/threshold : committed set driving the pipeline
//   mute, busy, commit_pulse, cfg_err, frame_cnt, vs_lost : status
// ---------------------------------------------------------------------------
module vp_cfg_sequencer
  import vp_cfg_pkg::*;
#(
  parameter int H_DISP         = 1280,
  parameter int V_DISP         = 720,
  parameter int SETTLE_FRAMES  = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vs_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [31:0]          cfg_cr,
  input  logic [31:0]          cfg_start,
  input  logic [31:0]          cfg_end,
  input  logic [31:0]          cfg_scaler,
  input  logic [31:0]          cfg_threshold,
  output logic [31:0]          act_cr,
  output logic [31:0]          act_start,
  output logic [31:0]          act_end,
  output logic [31:0]          act_scaler,
  output logic [31:0]          act_threshold,
  output logic                 mute,
  output logic                 busy,
  output logic                 commit_pulse,
  output logic                 cfg_err,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 vs_lost
);

  state_e         state_q, state_d;
  cfg_set_t       pend_q, pend_d;
  cfg_set_t       act_q, act_d;
  cfg_set_t       in_s, commit_src_s;
  logic [3:0]     settle_q, settle_d;
  logic           vs_q;
  logic           vs_rise_s;
  logic           cfg_ok_s;
  logic           accept_s;
  logic           take_s;
  logic           commit_s;
  logic           timeout_s;
  logic           ready_q, mute_q, busy_q, commit_pulse_q, cfg_err_q;
  logic [CNT_WIDTH-1:0] frame_cnt_q;

  assign in_s      = '{cr: cfg_cr, start: cfg_start, stop: cfg_end,
                       scaler: cfg_scaler, threshold: cfg_threshold};
  assign vs_rise_s = vs_in & ~vs_q;
  assign accept_s  = cfg_valid & ready_q;
  assign take_s    = accept_s & cfg_ok_s;
  // A set accepted in the commit cycle overrides the pending one.
  assign commit_src_s = take_s ? in_s : pend_q;

  vp_cfg_check #(
    .H_DISP(H_DISP),
    .V_DISP(V_DISP)
  ) u_check (
    .cr_i       (cfg_cr),
    .start_i    (cfg_start),
    .end_i      (cfg_end),
    .scaler_i   (cfg_scaler),
    .threshold_i(cfg_threshold),
    .cfg_ok_o   (cfg_ok_s)
  );

`ifdef VP_CFG_VS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q;
  logic             vs_lost_q;

  assign timeout_s = (state_q != ST_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles without a vs edge while a set is pending or settling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= {TMO_W{1'b0}};
    end else if ((state_q == ST_IDLE) || vs_rise_s || timeout_s) begin
      tmo_q <= {TMO_W{1'b0}};
    end else begin
      tmo_q <= tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky lost-sync flag; a new accepted set acknowledges it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_lost_q <= 1'b0;
    end else if (timeout_s) begin
      vs_lost_q <= 1'b1;
    end else if (take_s) begin
      vs_lost_q <= 1'b0;
    end else begin
      vs_lost_q <= vs_lost_q;
    end
  end

  assign vs_lost = vs_lost_q;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = (TIMEOUT_CYCLES > 0);
  assign timeout_s    = 1'b0;
  assign vs_lost      = 1'b0;
`endif

  // Next-state, pending-set and commit decisions.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    act_d    = act_q;
    settle_d = settle_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          pend_d  = in_s;
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (vs_rise_s || timeout_s) begin
          commit_s = 1'b1;
          act_d    = commit_src_s;
          pend_d   = commit_src_s;
          if (is_structural(commit_src_s, act_q)) begin
            state_d  = ST_MUTE;
            settle_d = 4'(SETTLE_FRAMES);
          end else begin
            state_d  = ST_IDLE;
          end
        end else if (take_s) begin
          pend_d = in_s;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_MUTE: begin
        if (timeout_s) begin
          settle_d = 4'd0;
          state_d  = ST_IDLE;
        end else if (vs_rise_s) begin
          if (settle_q <= 4'd1) begin
            settle_d = 4'd0;
            state_d  = ST_IDLE;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end else begin
          state_d = ST_MUTE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        settle_d = 4'd0;
      end
    endcase
  end

  // State, configuration registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pend_q         <= '0;
      act_q          <= '0;
      settle_q       <= 4'd0;
      vs_q           <= 1'b0;
      ready_q        <= 1'b1;
      mute_q         <= 1'b0;
      busy_q         <= 1'b0;
      commit_pulse_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      frame_cnt_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      act_q          <= act_d;
      settle_q       <= settle_d;
      vs_q           <= vs_in;
      ready_q        <= (state_d != ST_MUTE);
      mute_q         <= (state_d == ST_MUTE);
      busy_q         <= (state_d != ST_IDLE);
      commit_pulse_q <= commit_s;
      cfg_err_q      <= accept_s & ~cfg_ok_s;
      frame_cnt_q    <= frame_cnt_q + {{(CNT_WIDTH-1){1'b0}}, vs_rise_s};
    end
  end

  assign cfg_ready     = ready_q;
  assign mute          = mute_q;
  assign busy          = busy_q;
  assign commit_pulse  = commit_pulse_q;
  assign cfg_err       = cfg_err_q;
  assign frame_cnt     = frame_cnt_q;
  assign act_cr        = act_q.cr;
  assign act_start     = act_q.start;
  assign act_end       = act_q.stop;
  assign act_scaler    = act_q.scaler;
  assign act_threshold = act_q.threshold;

endmodule
